// File: rtl/mem_port_arbiter_if.sv
// Bundle of the signals between mem_port_arbiter, its two requesters and the
// unified memory.
//   fetch side : if_req, if_addr -> ; <- if_ack, if_rdata
//   data side  : d_req, d_we, d_addr, d_wdata -> ; <- d_ack, d_rdata
//   memory side: <- mem_addr, mem_wdata, mem_write ; mem_rdata ->
// slave is the arbiter's view. master is the view of the environment around
// it (requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_write
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the single shared instruction/data memory
// between the fetch unit (read only) and the load/store unit (read/write).
// Ties are broken round-robin. Each access holds the address for WAIT_CYCLES
// cycles. The owner then gets a one-cycle ack with registered read data.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave (requester handshakes + memory port)
//   busy  - high whenever the sequencer is not idle
module mem_port_arbiter #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1   // 1..15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_port_arbiter_if.slave      bus,
  output logic                   busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

  // Everything captured at grant; requester inputs are ignored after that.
  typedef struct packed {
    owner_t            owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  state_t            state, state_nxt;
  txn_t              txn;
  owner_t            last_grant;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic   grant;
  owner_t grant_owner;
  logic   final_cyc;

  assign final_cyc = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_owner = FETCH;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant = 1'b1;
          // On a tie, the requester not served last time wins.
          if (bus.if_req && bus.d_req)
            grant_owner = (last_grant == DATA) ? FETCH : DATA;
          else
            grant_owner = bus.d_req ? DATA : FETCH;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn        <= '0;
      last_grant <= DATA;   // fetch wins the first tie
      cnt        <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant) begin
        txn.owner  <= grant_owner;
        txn.addr   <= (grant_owner == DATA) ? bus.d_addr : bus.if_addr;
        if (grant_owner == DATA) begin
          txn.we    <= bus.d_we;
          txn.wdata <= bus.d_wdata;
        end
        last_grant <= grant_owner;
        cnt        <= CNT_LOAD;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Memory reads combinationally; the word is stable by the last cycle.
      if (final_cyc) begin
        if (txn.owner == FETCH)  if_rdata_q <= bus.mem_rdata;
        else if (!txn.we)        d_rdata_q  <= bus.mem_rdata;
      end
    end
  end

  // mem_addr/mem_wdata come straight from the latched transaction, so they
  // hold their last value outside ACCESS. The write strobe is limited to the
  // final cycle so a store produces exactly one write edge.
  assign bus.mem_addr  = txn.addr;
  assign bus.mem_wdata = txn.wdata;
  assign bus.mem_write = final_cyc && (txn.owner == DATA) && txn.we;
  assign bus.if_ack    = (state == DONE) && (txn.owner == FETCH);
  assign bus.d_ack     = (state == DONE) && (txn.owner == DATA);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances are used: index 0
// runs with WAIT_CYCLES=1 and index 1 with WAIT_CYCLES=3. Each has its own
// behavioural memory.
module tb_mem_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_t   [2];
  logic          if_req_t  [2];
  logic          d_req_t   [2];
  logic          d_we_t    [2];
  logic [AW-1:0] if_addr_t [2];
  logic [AW-1:0] d_addr_t  [2];
  logic [DW-1:0] d_wdata_t [2];
  logic          if_ack_t  [2];
  logic          d_ack_t   [2];
  logic          mem_write_t [2];
  logic          busy_t    [2];
  logic [DW-1:0] if_rdata_t[2];
  logic [DW-1:0] d_rdata_t [2];
  logic [DW-1:0] mem_wdata_t [2];
  logic [AW-1:0] mem_addr_t  [2];

  logic [DW-1:0] mem       [2][NW];
  logic [DW-1:0] model_mem [2][NW];
  logic [DW-1:0] exp_d     [2];
  logic          init_req;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      0:       return 32'h00011800;
      1:       return 32'h08000002;
      8:       return 32'h0040000d;
      default: return 32'hA5000000 ^ (32'(a) * 32'h00010203);
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.if_req    = if_req_t[g];
    assign bus.if_addr   = if_addr_t[g];
    assign bus.d_req     = d_req_t[g];
    assign bus.d_we      = d_we_t[g];
    assign bus.d_addr    = d_addr_t[g];
    assign bus.d_wdata   = d_wdata_t[g];
    assign bus.mem_rdata = mem[g][bus.mem_addr];
    assign if_ack_t[g]    = bus.if_ack;
    assign d_ack_t[g]     = bus.d_ack;
    assign if_rdata_t[g]  = bus.if_rdata;
    assign d_rdata_t[g]   = bus.d_rdata;
    assign mem_addr_t[g]  = bus.mem_addr;
    assign mem_wdata_t[g] = bus.mem_wdata;
    assign mem_write_t[g] = bus.mem_write;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk  (clk),
      .rst_n(rst_n_t[g]),
      .bus  (bus),
      .busy (busy_t[g])
    );
  end

  // Unified memory: synchronous write, combinational read.
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      for (int a = 0; a < NW; a++)
        if (init_req) mem[g][a] <= init_word(a);
        else if (mem_write_t[g] && mem_addr_t[g] == AW'(a)) mem[g][a] <= mem_wdata_t[g];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs(input int s);
    return {if_ack_t[s], d_ack_t[s], mem_write_t[s], busy_t[s],
            |if_rdata_t[s], |d_rdata_t[s], |mem_addr_t[s], |mem_wdata_t[s]};
  endfunction

  task automatic rst_seq(input int s);
    @(negedge clk);
    rst_n_t[s] = 1'b0; if_req_t[s] = 1'b0; d_req_t[s] = 1'b0; init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0; rst_n_t[s] = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int a = 0; a < NW; a++) model_mem[g][a] = init_word(a);
    exp_d[s] = '0;
  endtask

  typedef struct {
    int            s;
    bit            is_fetch;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;     // owner's rdata after the ack
    logic [DW-1:0] exp_other;  // other requester's rdata, must be untouched
  } vec_t;

  task automatic run_txn(input vec_t v, output int lat, output int nwr, output int nwr_ok,
                         output int nbusy, output int naddr, output int oack, output int busy_after);
    int s;
    s = v.s;
    lat = 0; nwr = 0; nwr_ok = 0; nbusy = 0; naddr = 0; oack = 0; busy_after = 1;
    @(negedge clk);
    if (v.is_fetch) begin
      if_req_t[s] = 1'b1; if_addr_t[s] = v.addr;
    end else begin
      d_req_t[s] = 1'b1; d_we_t[s] = v.we; d_addr_t[s] = v.addr; d_wdata_t[s] = v.wdata;
    end
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (busy_t[s]) nbusy++;
      if (mem_write_t[s]) begin
        nwr++;
        if (mem_addr_t[s] == v.addr && mem_wdata_t[s] == v.wdata) nwr_ok++;
      end
      if (busy_t[s] && !if_ack_t[s] && !d_ack_t[s] && mem_addr_t[s] == v.addr) naddr++;
      if (v.is_fetch ? d_ack_t[s] : if_ack_t[s]) oack = 1;
      if (v.is_fetch ? if_ack_t[s] : d_ack_t[s]) lat = k;
    end
    if_req_t[s] = 1'b0; d_req_t[s] = 1'b0;
    @(negedge clk);
    busy_after = int'(busy_t[s]);
  endtask

  task automatic rand_fetch(input int s, input int n);
    int oth; bit got; logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = AW'($urandom);
      if_addr_t[s] = a; if_req_t[s] = 1'b1;
      oth = 0; got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk);
        if (d_ack_t[s]) oth++;
        if (if_ack_t[s]) begin
          got = 1'b1;
          check("rnd_fetch_data", if_rdata_t[s], model_mem[s][a]);
        end
      end
      check("rnd_fetch_ack", 32'(got), 32'd1);
      check("rnd_fetch_fair", 32'(oth <= 1), 32'd1);
      if_req_t[s] = 1'b0;
    end
  endtask

  task automatic rand_data(input int s, input int n);
    int oth, nwr; bit got, we; logic [AW-1:0] a; logic [DW-1:0] wd;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = AW'($urandom); wd = $urandom; we = 1'($urandom_range(0, 1));
      d_addr_t[s] = a; d_wdata_t[s] = wd; d_we_t[s] = we; d_req_t[s] = 1'b1;
      oth = 0; nwr = 0; got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk);
        if (if_ack_t[s]) oth++;
        if (mem_write_t[s] && mem_addr_t[s] == a && mem_wdata_t[s] == wd) nwr++;
        else if (mem_write_t[s]) nwr += 10;
        if (d_ack_t[s]) begin
          got = 1'b1;
          if (we) begin
            check("rnd_store_keep_rdata", d_rdata_t[s], exp_d[s]);
            model_mem[s][a] = wd;
          end else begin
            check("rnd_load_data", d_rdata_t[s], model_mem[s][a]);
            exp_d[s] = model_mem[s][a];
          end
        end
      end
      check("rnd_data_ack", 32'(got), 32'd1);
      check("rnd_data_fair", 32'(oth <= 1), 32'd1);
      check("rnd_data_writes", 32'(nwr), 32'(we));
      d_req_t[s] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int lat, nwr, nwr_ok, nbusy, naddr, oack, busy_after, w;
    int order[$];
    int last_k;
    logic [DW-1:0] other_rd;

    for (int s = 0; s < 2; s++) begin
      rst_n_t[s] = 1'b0; if_req_t[s] = 1'b0; d_req_t[s] = 1'b0; d_we_t[s] = 1'b0;
      if_addr_t[s] = '0; d_addr_t[s] = '0; d_wdata_t[s] = '0; exp_d[s] = '0;
    end
    init_req = 1'b1;

    // Reset with random inputs: every output stays at 0.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      init_req = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if_req_t[s] = 1'($urandom); d_req_t[s] = 1'($urandom); d_we_t[s] = 1'($urandom);
        if_addr_t[s] = AW'($urandom); d_addr_t[s] = AW'($urandom); d_wdata_t[s] = $urandom;
      end
      #1;
      for (int s = 0; s < 2; s++) check("reset_outputs", 32'(outs(s)), 32'd0);
    end
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      if_req_t[s] = 1'b0; d_req_t[s] = 1'b0; rst_n_t[s] = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) check("post_reset_idle", 32'(outs(s)), 32'd0);
    end

    // Directed single transactions.
    vt[0]  = '{0, 1, 0, 6'd0,  32'h0,        32'h00011800, 32'h0};
    vt[1]  = '{0, 0, 1, 6'd20, 32'hDEADBEEF, 32'h0,        32'h00011800};
    vt[2]  = '{0, 1, 0, 6'd20, 32'h0,        32'hDEADBEEF, 32'h0};
    vt[3]  = '{0, 0, 0, 6'd20, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vt[4]  = '{0, 0, 1, 6'd63, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[5]  = '{0, 0, 0, 6'd63, 32'h0,        32'h12345678, 32'hDEADBEEF};
    vt[6]  = '{0, 1, 0, 6'd63, 32'h0,        32'h12345678, 32'h12345678};
    vt[7]  = '{1, 0, 0, 6'd1,  32'h0,        32'h08000002, 32'h0};
    vt[8]  = '{1, 1, 0, 6'd0,  32'h0,        32'h00011800, 32'h08000002};
    vt[9]  = '{1, 0, 1, 6'd0,  32'hCAFEF00D, 32'h08000002, 32'h00011800};
    vt[10] = '{1, 1, 0, 6'd0,  32'h0,        32'hCAFEF00D, 32'h08000002};

    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i], lat, nwr, nwr_ok, nbusy, naddr, oack, busy_after);
      w = (vt[i].s == 1) ? 3 : 1;
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(w + 1));
      check($sformatf("v%0d_busy_cycles", i), 32'(nbusy), 32'(w + 1));
      check($sformatf("v%0d_addr_cycles", i), 32'(naddr), 32'(w));
      check($sformatf("v%0d_writes", i), 32'(nwr), 32'(vt[i].we));
      check($sformatf("v%0d_write_target", i), 32'(nwr_ok), 32'(vt[i].we));
      check($sformatf("v%0d_other_ack", i), 32'(oack), 32'd0);
      check($sformatf("v%0d_busy_after", i), 32'(busy_after), 32'd0);
      check($sformatf("v%0d_owner_rdata", i),
            vt[i].is_fetch ? if_rdata_t[vt[i].s] : d_rdata_t[vt[i].s], vt[i].exp_rd);
      other_rd = vt[i].is_fetch ? d_rdata_t[vt[i].s] : if_rdata_t[vt[i].s];
      check($sformatf("v%0d_other_rdata", i), other_rd, vt[i].exp_other);
    end

    // Tie held from reset release: FETCH, DATA, FETCH, DATA, grants W+2 apart.
    @(negedge clk);
    rst_n_t[0] = 1'b0;
    @(negedge clk);
    if_addr_t[0] = 6'd8; d_addr_t[0] = 6'd1; d_we_t[0] = 1'b0;
    if_req_t[0] = 1'b1; d_req_t[0] = 1'b1;
    @(negedge clk);
    rst_n_t[0] = 1'b1;
    last_k = 0;
    for (int k = 1; k <= 60 && order.size() < 4; k++) begin
      @(negedge clk);
      if (if_ack_t[0] || d_ack_t[0]) begin
        check("tie_spacing", 32'(k - last_k), (last_k == 0) ? 32'd2 : 32'd3);
        last_k = k;
        order.push_back(if_ack_t[0] ? 0 : 1);
        if (if_ack_t[0]) check("tie_fetch_rdata", if_rdata_t[0], 32'h0040000d);
        else             check("tie_load_rdata", d_rdata_t[0], 32'h08000002);
      end
    end
    if_req_t[0] = 1'b0; d_req_t[0] = 1'b0;
    check("tie_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++)
      check($sformatf("tie_order_%0d", i), 32'(order[i]), 32'(i % 2));

    // Reset during the 2nd ACCESS cycle of a store (WAIT_CYCLES=3).
    @(negedge clk);
    d_req_t[1] = 1'b1; d_we_t[1] = 1'b1; d_addr_t[1] = 6'd9; d_wdata_t[1] = 32'hBAD0BAD0;
    oack = 0; nwr = 0;
    @(negedge clk);   // 1st ACCESS cycle
    nwr += int'(mem_write_t[1]);
    @(negedge clk);   // 2nd ACCESS cycle
    nwr += int'(mem_write_t[1]);
    check("abort_busy_before", 32'(busy_t[1]), 32'd1);
    rst_n_t[1] = 1'b0;
    #1;
    check("abort_outputs", 32'(outs(1)), 32'd0);
    d_req_t[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nwr += int'(mem_write_t[1]);
      oack += int'(d_ack_t[1] | if_ack_t[1]);
      if (c == 2) rst_n_t[1] = 1'b1;
    end
    check("abort_writes", 32'(nwr), 32'd0);
    check("abort_ack", 32'(oack), 32'd0);
    check("abort_word9", mem[1][9], init_word(9));

    // Randomized concurrent traffic against the transaction-level model.
    for (int s = 0; s < 2; s++) begin
      rst_seq(s);
      fork
        rand_fetch(s, 30);
        rand_data(s, 30);
      join
      repeat (6) @(negedge clk);
      check("rnd_idle_at_end", 32'(busy_t[s]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
